shot_control_multi: RTL and testbench
=====================================

SHOT_CONTROL_MULTI -- requirements
Module: shot_control_multi

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent start/shot channels (range 1..16).
REQ-002 The block SHALL have parameter DEBOUNCE, default 4, giving the press-qualification length in cycles (range 1..255).
REQ-003 The block SHALL have parameter MODE, default 0, selecting the output mode: 0 LATCH, 1 PULSE, 2 TOGGLE.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port start, input, CHANNELS bits: raw per-channel start request, active high.
REQ-007 The block SHALL have port clear, input, CHANNELS bits: per-channel synchronous return to IDLE, active high.
REQ-008 The block SHALL have port shot, output, CHANNELS bits: per-channel registered shot output.
REQ-009 The block SHALL have port busy, output, CHANNELS bits: high while the channel is in QUAL.
REQ-010 The block SHALL have port any_shot, output, 1 bit: OR of all shot bits.

Function
REQ-011 Each channel SHALL run an independent FSM with states INIT, IDLE, QUAL, SET and READY, plus an 8-bit qualification counter and an armed flag.
REQ-012 INIT SHALL go to IDLE unconditionally on the next edge.
REQ-013 From IDLE or READY, with start=1, the channel SHALL go to QUAL with counter=1; otherwise it stays.
REQ-014 In QUAL, start=1 with counter==DEBOUNCE SHALL go to SET (the press event); start=1 with counter<DEBOUNCE SHALL increment the counter.
REQ-015 In QUAL, start=0 SHALL abort to READY if armed, else to IDLE; the counter SHALL clear and no event occurs.
REQ-016 A press event SHALL therefore require start sampled high on DEBOUNCE+1 consecutive edges.
REQ-017 In SET, start=0 SHALL go to READY (release is not debounced); start=1 SHALL stay in SET.
REQ-018 The press event SHALL set armed; only reset or clear SHALL clear armed.
REQ-019 LATCH mode: shot SHALL go high at the edge of the press event and stay high until reset or clear.
REQ-020 PULSE mode: shot SHALL be high for exactly the one cycle following each press event edge.
REQ-021 TOGGLE mode: shot SHALL invert at each press event edge.
REQ-022 Shot SHALL be registered; there is no combinational path from start to shot.
REQ-023 Holding start high in SET SHALL NOT produce further events; a new event requires a release to READY and a new qualification.
REQ-024 clear[i]=1 SHALL, at the next edge, force channel i to IDLE with counter=0, armed=0 and shot=0, overriding start and any pending event in that cycle.
REQ-025 busy[i] SHALL equal (state==QUAL) combinationally from the state register.
REQ-026 Channels SHALL NOT interact; simultaneous events on several channels SHALL each be honoured in the same cycle.
REQ-027 Illegal state encodings SHALL return to INIT on the next edge with shot=0.

Reset
REQ-028 With reset=0 at an edge, every channel SHALL enter INIT with counter=0, armed=0 and shot=0; reset SHALL have priority over clear and start.
REQ-029 Reset asserted mid-qualification or mid-pulse SHALL discard the event; no shot SHALL appear after reset is released until a new full qualification.
REQ-030 After reset, outputs SHALL read shot=0, busy=0 and any_shot=0.

Structure
REQ-031 Package shot_ctrl_pkg SHALL hold the state encoding (3-bit: INIT, IDLE, QUAL, SET, READY), the MODE constants (MODE_LATCH, MODE_PULSE, MODE_TOGGLE) and the counter width constant (8).
REQ-032 Per-channel logic SHALL live in sub-module shot_channel (parameters DEBOUNCE, MODE), instantiated CHANNELS times by a generate loop; the top SHALL contain only instantiation and the any_shot reduction.

Verification
REQ-033 Reset then idle, LATCH, DEBOUNCE=4: start[0] high for 5 edges -> shot[0] rises after the 5th edge, busy[0] high for 4 cycles before it, and shot[0] stays high after start drops.
REQ-034 Glitch rejection, DEBOUNCE=4: start[1] high for 3 edges then low -> shot[1] stays 0, channel returns to IDLE, busy[1] drops.
REQ-035 PULSE mode: two qualified presses separated by a release -> exactly two 1-cycle shot pulses; holding start for 20 cycles gives only one pulse.
REQ-036 TOGGLE mode: three qualified presses -> shot reads 1, 0, 1; clear asserted the same cycle as a qualifying edge -> shot=0 and the channel is in IDLE.
REQ-037 CHANNELS=4: identical start on channels 0 and 3 -> both shots rise in the same cycle and any_shot=1; reset pulsed low mid-QUAL on channel 2 -> no shot on channel 2.

Source files
------------

// File: rtl/shot_ctrl_pkg.sv
// Shared definitions for the debounced start/shot controller:
// channel state encoding, output mode selectors and counter width.
package shot_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_QUAL  = 3'd2,
        ST_SET   = 3'd3,
        ST_READY = 3'd4
    } state_t;

    localparam int unsigned MODE_LATCH  = 0;
    localparam int unsigned MODE_PULSE  = 1;
    localparam int unsigned MODE_TOGGLE = 2;

    localparam int unsigned CNT_W = 8;

    // Value the shot register takes on a qualified press, given its current value.
    function automatic logic shot_on_event(input int unsigned mode, input logic cur);
        case (mode)
            MODE_TOGGLE: shot_on_event = ~cur;
            default:     shot_on_event = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/shot_channel.sv
// One debounced start/shot channel: qualifies a start press over DEBOUNCE+1
// consecutive high samples and drives a registered shot output per MODE.
module shot_channel
    import shot_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned MODE     = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic shot,
    output logic busy
);

    localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_shot;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_shot  <= 1'b0;
        end else if (clear) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_shot  <= 1'b0;
        end else begin
            // Pulse mode: shot falls on every edge unless a press event re-raises it.
            if (MODE == MODE_PULSE)
                r_shot <= 1'b0;
            case (r_state)
                ST_INIT: r_state <= ST_IDLE;
                ST_IDLE, ST_READY: begin
                    if (start) begin
                        r_state <= ST_QUAL;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ST_QUAL: begin
                    if (start) begin
                        if (r_cnt >= DEB) begin
                            r_state <= ST_SET;
                            r_cnt   <= '0;
                            r_armed <= 1'b1;
                            r_shot  <= shot_on_event(MODE, r_shot);
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_state <= r_armed ? ST_READY : ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
                ST_SET: begin
                    if (!start)
                        r_state <= ST_READY;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                    r_shot  <= 1'b0;
                end
            endcase
        end
    end

    assign shot = r_shot;
    assign busy = (r_state == ST_QUAL);

endmodule

// File: rtl/shot_control_multi.sv
// Multi-channel start/shot controller: CHANNELS independent debounced
// channels plus an OR of all shot outputs.
module shot_control_multi #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned MODE     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] clear,
    output logic [CHANNELS-1:0] shot,
    output logic [CHANNELS-1:0] busy,
    output logic                any_shot
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        shot_channel #(
            .DEBOUNCE (DEBOUNCE),
            .MODE     (MODE)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .start (start[g]),
            .clear (clear[g]),
            .shot  (shot[g]),
            .busy  (busy[g])
        );
    end

    assign any_shot = |shot;

endmodule

// File: tb/tb_shot_control_multi.sv
// Bench for shot_control_multi: one instance per output mode sharing stimulus,
// directed vector table, hand sequences, then random traffic vs a run-length model.
module tb_shot_control_multi;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start;
    logic [3:0] clear;
    logic [3:0] shot_l, busy_l, shot_p, busy_p, shot_t, busy_t;
    logic       any_l, any_p, any_t;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shot_control_multi #(.CHANNELS(4), .DEBOUNCE(D), .MODE(0)) u_latch (
        .clk(clk), .reset(rst_n), .start(start), .clear(clear),
        .shot(shot_l), .busy(busy_l), .any_shot(any_l));
    shot_control_multi #(.CHANNELS(4), .DEBOUNCE(D), .MODE(1)) u_pulse (
        .clk(clk), .reset(rst_n), .start(start), .clear(clear),
        .shot(shot_p), .busy(busy_p), .any_shot(any_p));
    shot_control_multi #(.CHANNELS(4), .DEBOUNCE(D), .MODE(2)) u_toggle (
        .clk(clk), .reset(rst_n), .start(start), .clear(clear),
        .shot(shot_t), .busy(busy_t), .any_shot(any_t));

    typedef struct {
        logic       rst;
        logic [3:0] st;
        logic [3:0] cl;
        logic [3:0] exp_shot;
        logic [3:0] exp_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [3:0] s, logic [3:0] c,
                                logic [3:0] sh, logic [3:0] b);
        vec_t v;
        v.rst = r; v.st = s; v.cl = c; v.exp_shot = sh; v.exp_busy = b;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a press event is the edge on which start has been
    // sampled high for exactly D+1 consecutive eligible edges.
    int   m_run [4];
    bit   m_init[4];
    logic m_shot[3][4];

    task automatic model_edge();
        bit ev;
        for (int c = 0; c < 4; c++) begin
            ev = 0;
            if (!rst_n) begin
                m_run[c] = 0; m_init[c] = 1;
                for (int m = 0; m < 3; m++) m_shot[m][c] = 0;
            end else if (clear[c]) begin
                m_run[c] = 0; m_init[c] = 0;
                for (int m = 0; m < 3; m++) m_shot[m][c] = 0;
            end else begin
                if (m_init[c]) begin
                    m_init[c] = 0;
                end else if (start[c]) begin
                    if (m_run[c] < 1000) m_run[c]++;
                    ev = (m_run[c] == D + 1);
                end else begin
                    m_run[c] = 0;
                end
                m_shot[0][c] = m_shot[0][c] | ev;
                m_shot[1][c] = ev;
                m_shot[2][c] = m_shot[2][c] ^ ev;
            end
        end
    endtask

    initial begin
        int pulses;
        logic [3:0] es [3];
        logic [3:0] eb;
        logic [3:0] act_s [3];
        logic [3:0] act_b [3];

        rst_n = 1'b0; start = '0; clear = '0;

        // Directed table against the LATCH instance.
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 4'b1001, 4'b0000, 4'b0000, 4'b1001));
        tbl.push_back(mk(1, 4'b1001, 4'b0000, 4'b1001, 4'b0000));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b1001, 4'b0000));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 4'b0010, 4'b0000, 4'b1001, 4'b0010));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b1001, 4'b0000));
        tbl.push_back(mk(1, 4'b0100, 4'b0000, 4'b1001, 4'b0100));
        tbl.push_back(mk(1, 4'b0100, 4'b0000, 4'b1001, 4'b0100));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000, 4'b0100));
        tbl.push_back(mk(1, 4'b0100, 4'b0000, 4'b0100, 4'b0000));
        tbl.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000));
        tbl.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000, 4'b0100));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000));

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst; start = tbl[i].st; clear = tbl[i].cl;
            tick();
            chk($sformatf("vec%0d shot", i), shot_l, tbl[i].exp_shot);
            chk($sformatf("vec%0d busy", i), busy_l, tbl[i].exp_busy);
            chk($sformatf("vec%0d any_shot", i), {3'b000, any_l}, {3'b000, |tbl[i].exp_shot});
        end

        // PULSE: a 20-cycle hold yields one pulse, a second press yields another.
        rst_n = 1'b0; start = '0; clear = '0; tick();
        rst_n = 1'b1; tick();
        pulses = 0;
        start = 4'b0001;
        for (int i = 0; i < 20; i++) begin tick(); if (shot_p[0]) pulses++; end
        start = 4'b0000;
        for (int i = 0; i < 2; i++) begin tick(); if (shot_p[0]) pulses++; end
        chk("pulse hold count", 4'(pulses), 4'd1);
        start = 4'b0001;
        for (int i = 0; i < 5; i++) begin tick(); if (shot_p[0]) pulses++; end
        chk("pulse second press high", {3'b000, shot_p[0]}, 4'b0001);
        start = 4'b0000;
        for (int i = 0; i < 3; i++) begin tick(); if (shot_p[0]) pulses++; end
        chk("pulse total count", 4'(pulses), 4'd2);

        // TOGGLE: three presses read 1,0,1.
        clear = 4'b1111; tick();
        clear = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            start = 4'b0001;
            for (int i = 0; i < 5; i++) tick();
            chk($sformatf("toggle press%0d", k), {3'b000, shot_t[0]}, {3'b000, (k != 1)});
            start = 4'b0000; tick();
        end

        // Clear on the qualifying edge wins; channel restarts from IDLE.
        start = 4'b0001;
        for (int i = 0; i < 4; i++) tick();
        clear = 4'b0001; tick();
        chk("clear vs event latch shot", {3'b000, shot_l[0]}, 4'b0000);
        chk("clear vs event toggle shot", {3'b000, shot_t[0]}, 4'b0000);
        chk("clear vs event busy", {3'b000, busy_t[0]}, 4'b0000);
        clear = 4'b0000; tick();
        chk("after clear requalifies", {3'b000, busy_t[0]}, 4'b0001);
        start = 4'b0000; tick();

        // Random traffic against the run-length model, all three modes.
        rst_n = 1'b0; model_edge(); tick();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst_n = ($urandom_range(299) != 0);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(5) == 0) start[c] = ~start[c];
                clear[c] = ($urandom_range(59) == 0);
            end
            model_edge();
            tick();
            eb = '0;
            for (int c = 0; c < 4; c++) begin
                eb[c] = (m_run[c] >= 1) && (m_run[c] <= D);
                for (int m = 0; m < 3; m++) es[m][c] = m_shot[m][c];
            end
            act_s[0] = shot_l; act_s[1] = shot_p; act_s[2] = shot_t;
            act_b[0] = busy_l; act_b[1] = busy_p; act_b[2] = busy_t;
            for (int m = 0; m < 3; m++) begin
                chk($sformatf("rand c%0d m%0d shot", cyc, m), act_s[m], es[m]);
                chk($sformatf("rand c%0d m%0d busy", cyc, m), act_b[m], eb);
            end
            chk($sformatf("rand c%0d any_shot", cyc),
                {1'b0, any_t, any_p, any_l}, {1'b0, |es[2], |es[1], |es[0]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
